// File: rtl/sort_mem_pkg.sv
// Shared definitions for the sort memory responder: response codes,
// read-channel FSM states and the address range check.
package sort_mem_pkg;

   localparam int RESP_OKAY   = 0;
   localparam int RESP_SLVERR = 1;

   typedef enum logic [1:0] {
      RD_IDLE = 2'd0,
      RD_WAIT = 2'd1,
      RD_RESP = 2'd2
   } rd_state_t;

   // Addresses are unsigned and never wrap; anything at or past depth is an error.
   function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
      return (addr < depth);
   endfunction

endpackage

// File: rtl/sort_mem_responder_if.sv
// Read (AR/R) and write (AW/W/B) channel bundle between the sort datapath
// (master) and the memory responder (slave).
interface sort_mem_responder_if #(
   parameter int ADDR_WDTH = 4,
   parameter int DATA_WDTH = 32,
   parameter int RESP_WDTH = 1
);
   logic                 ar_valid;
   logic                 ar_ready;
   logic [ADDR_WDTH-1:0] ar_address;
   logic                 r_valid;
   logic                 r_ready;
   logic [DATA_WDTH-1:0] r_data;
   logic [RESP_WDTH-1:0] r_resp;
   logic                 aw_valid;
   logic                 aw_ready;
   logic [ADDR_WDTH-1:0] aw_address;
   logic                 w_valid;
   logic                 w_ready;
   logic [DATA_WDTH-1:0] w_data;
   logic                 b_valid;
   logic                 b_ready;
   logic [RESP_WDTH-1:0] b_resp;

   modport master (
      output ar_valid, ar_address, r_ready, aw_valid, aw_address, w_valid, w_data, b_ready,
      input  ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
   );

   modport slave (
      input  ar_valid, ar_address, r_ready, aw_valid, aw_address, w_valid, w_data, b_ready,
      output ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
   );
endinterface

// File: rtl/sort_mem_array.sv
// Storage for the array under sort: one synchronous write port (preload has
// priority over a channel commit), one registered read sample and one
// combinational debug port. Define SORT_MEM_CLR_ON_RST_EN to zero every word on rst.
module sort_mem_array
   import sort_mem_pkg::*;
#(
   parameter int ADDR_WDTH = 4,
   parameter int DATA_WDTH = 32,
   parameter int MEM_DEPTH = 2**ADDR_WDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 init_we,
   input  logic [ADDR_WDTH-1:0] init_addr,
   input  logic [DATA_WDTH-1:0] init_data,
   input  logic                 wr_en,
   input  logic [ADDR_WDTH-1:0] wr_addr,
   input  logic [DATA_WDTH-1:0] wr_data,
   input  logic                 rd_en,
   input  logic [ADDR_WDTH-1:0] rd_addr,
   output logic [DATA_WDTH-1:0] rd_data,
   input  logic [ADDR_WDTH-1:0] dbg_addr,
   output logic [DATA_WDTH-1:0] dbg_data
);
   logic [DATA_WDTH-1:0] mem [MEM_DEPTH];
   logic init_ok;
   logic wr_ok;
   logic rd_ok;
   logic dbg_ok;

   assign init_ok = init_we && addr_in_range(32'(init_addr), MEM_DEPTH);
   assign wr_ok   = wr_en   && addr_in_range(32'(wr_addr),   MEM_DEPTH);
   assign rd_ok   = addr_in_range(32'(rd_addr),  MEM_DEPTH);
   assign dbg_ok  = addr_in_range(32'(dbg_addr), MEM_DEPTH);

   // Single write port: preload beats a same-edge channel commit.
   always_ff @(posedge clk) begin
`ifdef SORT_MEM_CLR_ON_RST_EN
      if (rst) begin
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else
`endif
      if (init_ok) begin
         mem[init_addr] <= init_data;
      end else if (wr_ok) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Registered sample; holds between samples so r_data stays stable until consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= rd_ok ? mem[rd_addr] : '0;
      end
   end

   assign dbg_data = dbg_ok ? mem[dbg_addr] : '0;

endmodule

// File: rtl/sort_mem_responder.sv
// Memory-side responder for the insertion-sort datapath. Serves one read and
// one write at a time over valid/ready channels. Optional SORT_MEM_CLR_ON_RST_EN
// (see sort_mem_array) clears the storage on rst.
module sort_mem_responder
   import sort_mem_pkg::*;
#(
   parameter int ADDR_WDTH = 4,
   parameter int DATA_WDTH = 32,
   parameter int RESP_WDTH = 1,
   parameter int MEM_DEPTH = 2**ADDR_WDTH,
   parameter int RD_LAT    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   sort_mem_responder_if.slave  bus,
   input  logic                 init_we,
   input  logic [ADDR_WDTH-1:0] init_addr,
   input  logic [DATA_WDTH-1:0] init_data,
   input  logic [ADDR_WDTH-1:0] dbg_addr,
   output logic [DATA_WDTH-1:0] dbg_data
);
   localparam int CNT_WDTH = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   rd_state_t            rd_state_reg, rd_state_next;
   logic [CNT_WDTH-1:0]  rd_cnt_reg, rd_cnt_next;
   logic [ADDR_WDTH-1:0] rd_addr_reg, rd_addr_next;
   logic [RESP_WDTH-1:0] r_resp_reg, r_resp_next;
   logic [ADDR_WDTH-1:0] rd_sel_addr;
   logic                 rd_en;
   logic [DATA_WDTH-1:0] r_data_q;

   logic                 aw_held_reg, aw_held_next;
   logic [ADDR_WDTH-1:0] aw_addr_reg, aw_addr_next;
   logic                 w_held_reg, w_held_next;
   logic [DATA_WDTH-1:0] w_data_reg, w_data_next;
   logic                 b_valid_reg, b_valid_next;
   logic [RESP_WDTH-1:0] b_resp_reg, b_resp_next;
   logic                 wr_en;

   // Read FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_state_reg <= RD_IDLE;
         rd_cnt_reg   <= '0;
         rd_addr_reg  <= '0;
         r_resp_reg   <= '0;
      end else begin
         rd_state_reg <= rd_state_next;
         rd_cnt_reg   <= rd_cnt_next;
         rd_addr_reg  <= rd_addr_next;
         r_resp_reg   <= r_resp_next;
      end
   end

   // Read FSM next state; with RD_LAT=1 the sample is taken on the AR edge itself.
   always_comb begin
      rd_state_next = rd_state_reg;
      rd_cnt_next   = rd_cnt_reg;
      rd_addr_next  = rd_addr_reg;
      r_resp_next   = r_resp_reg;
      rd_sel_addr   = rd_addr_reg;
      rd_en         = 1'b0;
      bus.ar_ready  = 1'b0;
      bus.r_valid   = 1'b0;
      case (rd_state_reg)
         RD_IDLE: begin
            bus.ar_ready = 1'b1;
            rd_sel_addr  = bus.ar_address;
            if (bus.ar_valid) begin
               rd_addr_next = bus.ar_address;
               if (RD_LAT == 1) begin
                  rd_en         = 1'b1;
                  rd_state_next = RD_RESP;
               end else begin
                  rd_cnt_next   = CNT_WDTH'(RD_LAT - 1);
                  rd_state_next = RD_WAIT;
               end
            end
         end
         RD_WAIT: begin
            if (rd_cnt_reg == CNT_WDTH'(1)) begin
               rd_en         = 1'b1;
               rd_state_next = RD_RESP;
            end else begin
               rd_cnt_next = rd_cnt_reg - CNT_WDTH'(1);
            end
         end
         RD_RESP: begin
            bus.r_valid = 1'b1;
            if (bus.r_ready) begin
               rd_state_next = RD_IDLE;
            end
         end
         default: rd_state_next = RD_IDLE;
      endcase
      if (rd_en) begin
         r_resp_next = addr_in_range(32'(rd_sel_addr), MEM_DEPTH) ?
                       RESP_WDTH'(RESP_OKAY) : RESP_WDTH'(RESP_SLVERR);
      end
   end

   // Write channel holding registers and response.
   always_ff @(posedge clk) begin
      if (rst) begin
         aw_held_reg <= 1'b0;
         aw_addr_reg <= '0;
         w_held_reg  <= 1'b0;
         w_data_reg  <= '0;
         b_valid_reg <= 1'b0;
         b_resp_reg  <= '0;
      end else begin
         aw_held_reg <= aw_held_next;
         aw_addr_reg <= aw_addr_next;
         w_held_reg  <= w_held_next;
         w_data_reg  <= w_data_next;
         b_valid_reg <= b_valid_next;
         b_resp_reg  <= b_resp_next;
      end
   end

   // Capture AW and W independently; commit one edge after both are held.
   always_comb begin
      aw_held_next = aw_held_reg;
      aw_addr_next = aw_addr_reg;
      w_held_next  = w_held_reg;
      w_data_next  = w_data_reg;
      b_valid_next = b_valid_reg;
      b_resp_next  = b_resp_reg;
      wr_en        = 1'b0;
      if (b_valid_reg) begin
         if (bus.b_ready) begin
            b_valid_next = 1'b0;
         end
      end else if (aw_held_reg && w_held_reg) begin
         wr_en        = 1'b1;
         b_valid_next = 1'b1;
         b_resp_next  = addr_in_range(32'(aw_addr_reg), MEM_DEPTH) ?
                        RESP_WDTH'(RESP_OKAY) : RESP_WDTH'(RESP_SLVERR);
         aw_held_next = 1'b0;
         w_held_next  = 1'b0;
      end else begin
         if (!aw_held_reg && bus.aw_valid) begin
            aw_held_next = 1'b1;
            aw_addr_next = bus.aw_address;
         end
         if (!w_held_reg && bus.w_valid) begin
            w_held_next = 1'b1;
            w_data_next = bus.w_data;
         end
      end
   end

   assign bus.aw_ready = !aw_held_reg && !b_valid_reg;
   assign bus.w_ready  = !w_held_reg  && !b_valid_reg;
   assign bus.b_valid  = b_valid_reg;
   assign bus.b_resp   = b_resp_reg;
   assign bus.r_resp   = r_resp_reg;
   assign bus.r_data   = r_data_q;

   sort_mem_array #(
      .ADDR_WDTH (ADDR_WDTH),
      .DATA_WDTH (DATA_WDTH),
      .MEM_DEPTH (MEM_DEPTH)
   ) u_array (
      .clk       (clk),
      .rst       (rst),
      .init_we   (init_we),
      .init_addr (init_addr),
      .init_data (init_data),
      .wr_en     (wr_en && !rst),
      .wr_addr   (aw_addr_reg),
      .wr_data   (w_data_reg),
      .rd_en     (rd_en),
      .rd_addr   (rd_sel_addr),
      .rd_data   (r_data_q),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_data)
   );

endmodule

// File: tb/tb_sort_mem_responder.sv
// Self-checking bench for sort_mem_responder: directed scenarios followed by
// randomized reads/writes, all checked against an array model of the memory.
module tb_sort_mem_responder;
   localparam int AW    = 4;
   localparam int DW    = 32;
   localparam int RW    = 1;
   localparam int DEPTH = 10;
   localparam int LAT   = 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          init_we;
   logic [AW-1:0] init_addr;
   logic [DW-1:0] init_data;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_data;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] model_mem [16];

   sort_mem_responder_if #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW)) bus ();

   sort_mem_responder #(
      .ADDR_WDTH (AW), .DATA_WDTH (DW), .RESP_WDTH (RW),
      .MEM_DEPTH (DEPTH), .RD_LAT (LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .init_we   (init_we),
      .init_addr (init_addr),
      .init_data (init_data),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_rd(input int a);
      return (a < DEPTH) ? model_mem[a] : 32'd0;
   endfunction

   function automatic logic [31:0] model_resp(input int a);
      return (a < DEPTH) ? 32'd0 : 32'd1;
   endfunction

   task automatic check_dbg(input int a);
      dbg_addr = AW'(a);
      #1;
      check_val("dbg", dbg_data, model_rd(a));
   endtask

   task automatic dbg_sweep();
      for (int a = 0; a < 16; a++) begin
         check_dbg(a);
      end
   endtask

   task automatic do_read(input int addr, input int hold);
      int cyc;
      logic [31:0] exp_d;
      cyc = 0;
      while (!bus.ar_ready && cyc < 20) begin tick(); cyc++; end
      check_val("ar_ready_wait", 32'(bus.ar_ready), 32'd1);
      bus.ar_valid   = 1'b1;
      bus.ar_address = AW'(addr);
      exp_d = model_rd(addr);
      tick();
      bus.ar_valid = 1'b0;
      cyc = 1;
      while (!bus.r_valid && cyc < 20) begin tick(); cyc++; end
      check_val("rd_lat", 32'(cyc), 32'(LAT));
      for (int h = 0; h < hold; h++) begin
         check_val("rd_hold_valid", 32'(bus.r_valid), 32'd1);
         check_val("rd_hold_arrdy", 32'(bus.ar_ready), 32'd0);
         check_val("rd_hold_data", bus.r_data, exp_d);
         tick();
      end
      check_val("rd_data", bus.r_data, exp_d);
      check_val("rd_resp", 32'(bus.r_resp), model_resp(addr));
      $display("rd addr=%0d data=%0h resp=%0d hold=%0d", addr, bus.r_data, bus.r_resp, hold);
      bus.r_ready = 1'b1;
      tick();
      bus.r_ready = 1'b0;
      check_val("rd_done", 32'(bus.r_valid), 32'd0);
   endtask

   // mode 0: AW and W together; 1: AW then W after gap; 2: W then AW after gap.
   task automatic do_write(input int addr, input logic [31:0] data, input int mode,
                           input int gap, input int bhold);
      int cyc;
      cyc = 0;
      while (!(bus.aw_ready && bus.w_ready) && cyc < 20) begin tick(); cyc++; end
      check_val("wr_ready_wait", 32'(bus.aw_ready && bus.w_ready), 32'd1);
      bus.aw_address = AW'(addr);
      bus.w_data     = data;
      if (mode == 0) begin
         bus.aw_valid = 1'b1;
         bus.w_valid  = 1'b1;
         tick();
         bus.aw_valid = 1'b0;
         bus.w_valid  = 1'b0;
      end else begin
         if (mode == 1) bus.aw_valid = 1'b1; else bus.w_valid = 1'b1;
         tick();
         bus.aw_valid = 1'b0;
         bus.w_valid  = 1'b0;
         for (int g = 1; g < gap; g++) tick();
         if (mode == 1) bus.w_valid = 1'b1; else bus.aw_valid = 1'b1;
         tick();
         bus.aw_valid = 1'b0;
         bus.w_valid  = 1'b0;
      end
      check_val("b_early", 32'(bus.b_valid), 32'd0);
      tick();
      check_val("b_valid", 32'(bus.b_valid), 32'd1);
      check_val("b_resp", 32'(bus.b_resp), model_resp(addr));
      if (addr < DEPTH) model_mem[addr] = data;
      for (int h = 0; h < bhold; h++) begin
         check_val("b_hold_valid", 32'(bus.b_valid), 32'd1);
         check_val("b_hold_rdy", 32'({bus.aw_ready, bus.w_ready}), 32'd0);
         tick();
      end
      $display("wr addr=%0d data=%0h mode=%0d gap=%0d resp=%0d", addr, data, mode, gap, bus.b_resp);
      bus.b_ready = 1'b1;
      tick();
      bus.b_ready = 1'b0;
      check_val("b_done", 32'(bus.b_valid), 32'd0);
      check_val("wr_rdy_back", 32'({bus.aw_ready, bus.w_ready}), 32'd3);
      check_dbg(addr);
   endtask

   initial begin
      logic [31:0] exp_d;
      int cyc;
      for (int i = 0; i < 16; i++) model_mem[i] = '0;
      init_we = 1'b0; init_addr = '0; init_data = '0; dbg_addr = '0;
      bus.ar_valid = 1'b0; bus.ar_address = '0; bus.r_ready = 1'b0;
      bus.aw_valid = 1'b0; bus.aw_address = '0; bus.w_valid = 1'b0;
      bus.w_data = '0; bus.b_ready = 1'b0;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;

      // Reset state
      check_val("rst_ar_ready", 32'(bus.ar_ready), 32'd1);
      check_val("rst_aw_ready", 32'(bus.aw_ready), 32'd1);
      check_val("rst_w_ready", 32'(bus.w_ready), 32'd1);
      check_val("rst_r_valid", 32'(bus.r_valid), 32'd0);
      check_val("rst_b_valid", 32'(bus.b_valid), 32'd0);
      check_val("rst_r_data", bus.r_data, 32'd0);
      check_val("rst_r_resp", 32'(bus.r_resp), 32'd0);
      check_val("rst_b_resp", 32'(bus.b_resp), 32'd0);

      // Preload; words past DEPTH must be ignored.
      for (int i = 0; i < 16; i++) begin
         init_we = 1'b1; init_addr = AW'(i); init_data = 32'(100 + i);
         tick();
         if (i < DEPTH) model_mem[i] = 32'(100 + i);
      end
      init_we = 1'b0;
      $display("preload done");
      dbg_sweep();

      do_read(5, 0);
      do_write(3, 32'hDEAD, 1, 2, 4);
      do_read(12, 1);
      do_write(11, 32'd7, 0, 1, 0);
      dbg_sweep();

      // Read sample and write commit to addr 4 on the same edge: old value returned.
      bus.aw_valid = 1'b1; bus.aw_address = 4'd4; bus.w_valid = 1'b1; bus.w_data = 32'h55;
      tick();
      bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
      bus.ar_valid = 1'b1; bus.ar_address = 4'd4;
      exp_d = model_rd(4);
      tick();
      bus.ar_valid = 1'b0;
      check_val("coll_r_valid", 32'(bus.r_valid), 32'd1);
      check_val("coll_r_data", bus.r_data, exp_d);
      check_val("coll_b_valid", 32'(bus.b_valid), 32'd1);
      $display("collision rd addr=4 data=%0h", bus.r_data);
      model_mem[4] = 32'h55;
      bus.r_ready = 1'b1; bus.b_ready = 1'b1;
      tick();
      bus.r_ready = 1'b0; bus.b_ready = 1'b0;
      do_read(4, 0);

      // Preload and channel commit to the same word on the same edge: preload wins.
      bus.aw_valid = 1'b1; bus.aw_address = 4'd6; bus.w_valid = 1'b1; bus.w_data = 32'h77;
      tick();
      bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
      init_we = 1'b1; init_addr = 4'd6; init_data = 32'h66;
      tick();
      init_we = 1'b0;
      check_val("prio_b_valid", 32'(bus.b_valid), 32'd1);
      check_val("prio_b_resp", 32'(bus.b_resp), 32'd0);
      model_mem[6] = 32'h66;
      $display("init priority addr=6");
      bus.b_ready = 1'b1;
      tick();
      bus.b_ready = 1'b0;
      check_dbg(6);

      // Randomized traffic
      for (int k = 0; k < 40; k++) begin
         int a;
         a = int'($urandom_range(15));
         if ($urandom_range(1) == 1)
            do_read(a, int'($urandom_range(3)));
         else
            do_write(a, $urandom, int'($urandom_range(2)), int'($urandom_range(3, 1)),
                     int'($urandom_range(3)));
      end
      dbg_sweep();

      // Stall the read, then reset while only AW is held.
      bus.ar_valid = 1'b1; bus.ar_address = 4'd2;
      exp_d = model_rd(2);
      tick();
      bus.ar_valid = 1'b0;
      cyc = 0;
      while (!bus.r_valid && cyc < 20) begin tick(); cyc++; end
      for (int h = 0; h < 5; h++) begin
         check_val("stall_r_valid", 32'(bus.r_valid), 32'd1);
         check_val("stall_r_data", bus.r_data, exp_d);
         check_val("stall_ar_ready", 32'(bus.ar_ready), 32'd0);
         tick();
      end
      bus.aw_valid = 1'b1; bus.aw_address = 4'd7;
      tick();
      bus.aw_valid = 1'b0;
      check_val("aw_held_rdy", 32'({bus.aw_ready, bus.w_ready}), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
`ifdef SORT_MEM_CLR_ON_RST_EN
      for (int i = 0; i < 16; i++) model_mem[i] = '0;
`endif
      $display("mid-transaction reset");
      check_val("mrst_r_valid", 32'(bus.r_valid), 32'd0);
      check_val("mrst_b_valid", 32'(bus.b_valid), 32'd0);
      check_val("mrst_readies", 32'({bus.ar_ready, bus.aw_ready, bus.w_ready}), 32'd7);
      check_val("mrst_r_data", bus.r_data, 32'd0);
      check_val("mrst_r_resp", 32'(bus.r_resp), 32'd0);
      check_dbg(7);

      // The dropped AW must not pair with a later W.
      bus.w_valid = 1'b1; bus.w_data = 32'hBAD;
      tick();
      bus.w_valid = 1'b0;
      tick(); tick();
      check_val("orphan_b_valid", 32'(bus.b_valid), 32'd0);
      check_val("orphan_rdy", 32'({bus.aw_ready, bus.w_ready}), 32'd2);
      check_dbg(7);
      bus.aw_valid = 1'b1; bus.aw_address = 4'd7;
      tick();
      bus.aw_valid = 1'b0;
      tick();
      check_val("late_b_valid", 32'(bus.b_valid), 32'd1);
      model_mem[7] = 32'hBAD;
      bus.b_ready = 1'b1;
      tick();
      bus.b_ready = 1'b0;
      check_dbg(7);
      $display("late aw completes addr=7");
      dbg_sweep();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
